// File: rtl/rgb_pwm_gen_pkg.sv
// Shared widths, FSM state type, colour payload and fade-step helper for the RGB PWM generator.
package rgb_pwm_gen_pkg;

  localparam int unsigned PWM_BITS = 8;
  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned SLOT_MAX = (1 << PWM_BITS) - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_FADING  = 2'd2
  } state_e;

  typedef struct packed {
    logic [PWM_BITS-1:0] r;
    logic [PWM_BITS-1:0] g;
    logic [PWM_BITS-1:0] b;
  } color_t;

  // Move one LSB toward the target; a channel already at target stays put.
  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    logic [PWM_BITS-1:0] nxt;
    nxt = cur;
    if (cur < tgt) begin
      nxt = cur + PWM_BITS'(1);
    end else if (cur > tgt) begin
      nxt = cur - PWM_BITS'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rgb_pwm_gen_channel.sv
// One colour channel: target and current duty registers, fade step and registered PWM comparator.
module rgb_pwm_gen_channel
  import rgb_pwm_gen_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                accept_i,
  input  logic [PWM_BITS-1:0] color_i,
  input  logic                load_i,
  input  logic                step_i,
  input  logic [PWM_BITS-1:0] slot_i,
  output logic                done_o,
  output logic                pwm_o
);

  logic [PWM_BITS-1:0] cur_q;
  logic [PWM_BITS-1:0] cur_d;
  logic [PWM_BITS-1:0] tgt_q;
  logic [PWM_BITS-1:0] tgt_d;
  logic                pwm_q;
  logic                pwm_d;

  // Next-state: latch a new target on accept; duty only moves on load or fade step (both tick-qualified).
  always_comb begin
    tgt_d = tgt_q;
    cur_d = cur_q;
    pwm_d = (slot_i < cur_q);
    if (accept_i) begin
      tgt_d = color_i;
    end
    if (load_i) begin
      cur_d = tgt_q;
    end else if (step_i) begin
      cur_d = step_toward(cur_q, tgt_q);
    end
  end

  // Duty, target and PWM output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tgt_q <= '0;
      cur_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      cur_q <= cur_d;
      pwm_q <= pwm_d;
    end
  end

  assign done_o = (cur_q == tgt_q);
  assign pwm_o  = pwm_q;

endmodule

// File: rtl/rgb_pwm_gen.sv
// RGB PWM enable generator: prescaler, slot counter, fade divider, snap/fade FSM and colour handshake.
module rgb_pwm_gen
  import rgb_pwm_gen_pkg::*;
#(
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned FADE_DIV = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_color_valid,
  output logic                o_color_ready,
  input  logic [PWM_BITS-1:0] i_color_r,
  input  logic [PWM_BITS-1:0] i_color_g,
  input  logic [PWM_BITS-1:0] i_color_b,
  input  logic                i_fade_en,
  output logic                o_pwm_r,
  output logic                o_pwm_g,
  output logic                o_pwm_b,
  output logic                o_busy,
  output logic                o_period_tick
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FD_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  logic [PS_W-1:0]     presc_q;
  logic [PS_W-1:0]     presc_d;
  logic [PWM_BITS-1:0] slot_q;
  logic [PWM_BITS-1:0] slot_d;
  logic [FD_W-1:0]     div_q;
  state_e              state_q;
  logic                moved_q;

  logic                slot_en;
  logic                period_tick;
  logic                accept;
  logic                div_wrap;
  logic                fade_step;
  logic                load;
  logic                all_done;
  logic [NUM_CH-1:0]   done;
  logic [NUM_CH-1:0]   pwm;
  color_t              req;

  assign o_color_ready = 1'b1;
  assign accept        = i_color_valid & o_color_ready;
  assign req           = {i_color_r, i_color_g, i_color_b};

  assign slot_en     = (presc_q == PS_W'(PRESCALE - 1));
  assign period_tick = slot_en & (slot_q == PWM_BITS'(SLOT_MAX));
  assign div_wrap    = (div_q == FD_W'(FADE_DIV - 1));
  assign fade_step   = (state_q == ST_FADING) & period_tick & div_wrap;
  assign load        = (state_q == ST_PENDING) & period_tick;
  assign all_done    = &done;

  // Prescaler and slot counter next-state.
  always_comb begin
    presc_d = presc_q + PS_W'(1);
    slot_d  = slot_q;
    if (slot_en) begin
      presc_d = '0;
      slot_d  = slot_q + PWM_BITS'(1);
    end
  end

  // Prescaler and PWM slot counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q <= '0;
      slot_q  <= '0;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
    end
  end

  // Mode FSM and fade divider; a new accept always wins and restarts the fade cadence.
  // moved_q lets a fade retire the cycle after its last step, while a fade that starts
  // already at target waits for its first step boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      moved_q <= 1'b0;
    end else if (accept) begin
      state_q <= i_fade_en ? ST_FADING : ST_PENDING;
      moved_q <= 1'b0;
      if (i_fade_en) begin
        div_q <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_PENDING: begin
          if (period_tick) begin
            state_q <= ST_IDLE;
          end
        end
        ST_FADING: begin
          if (period_tick) begin
            div_q <= div_wrap ? '0 : div_q + FD_W'(1);
          end
          if (fade_step) begin
            moved_q <= 1'b1;
          end
          if (all_done && (fade_step || moved_q)) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Red channel.
  rgb_pwm_gen_channel u_ch_r (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .accept_i (accept),
    .color_i  (req.r),
    .load_i   (load),
    .step_i   (fade_step),
    .slot_i   (slot_q),
    .done_o   (done[0]),
    .pwm_o    (pwm[0])
  );

  // Green channel.
  rgb_pwm_gen_channel u_ch_g (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .accept_i (accept),
    .color_i  (req.g),
    .load_i   (load),
    .step_i   (fade_step),
    .slot_i   (slot_q),
    .done_o   (done[1]),
    .pwm_o    (pwm[1])
  );

  // Blue channel.
  rgb_pwm_gen_channel u_ch_b (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .accept_i (accept),
    .color_i  (req.b),
    .load_i   (load),
    .step_i   (fade_step),
    .slot_i   (slot_q),
    .done_o   (done[2]),
    .pwm_o    (pwm[2])
  );

  assign o_pwm_r       = pwm[0];
  assign o_pwm_g       = pwm[1];
  assign o_pwm_b       = pwm[2];
  assign o_busy        = (state_q != ST_IDLE);
  assign o_period_tick = period_tick;

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Self-checking bench for rgb_pwm_gen with a behavioural duty/mode reference model.
module tb_rgb_pwm_gen;

  localparam int unsigned PRESCALE = 1;
  localparam int unsigned FADE_DIV = 2;
  localparam int unsigned PERIOD   = 256 * PRESCALE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       fade = 1'b0;
  logic [7:0] cr = 8'h00;
  logic [7:0] cg = 8'h00;
  logic [7:0] cb = 8'h00;
  logic       ready;
  logic       pwm_r;
  logic       pwm_g;
  logic       pwm_b;
  logic       busy;
  logic       tick;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rgb_pwm_gen #(
    .PRESCALE (PRESCALE),
    .FADE_DIV (FADE_DIV)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_color_valid (valid),
    .o_color_ready (ready),
    .i_color_r     (cr),
    .i_color_g     (cg),
    .i_color_b     (cb),
    .i_fade_en     (fade),
    .o_pwm_r       (pwm_r),
    .o_pwm_g       (pwm_g),
    .o_pwm_b       (pwm_b),
    .o_busy        (busy),
    .o_period_tick (tick)
  );

  // Reference model: time since reset, duty per channel, mode (0 idle, 1 snap pending, 2 fading).
  int unsigned m_cyc = 0;
  int          m_state = 0;
  int          m_ticks = 0;
  bit          m_moved = 1'b0;
  int          m_cur[3] = '{0, 0, 0};
  int          m_tgt[3] = '{0, 0, 0};

  function automatic bit m_tick_now();
    return (m_cyc % PERIOD) == (PERIOD - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit tk;
    bit stepnow;
    bit alldone;
    int nc[3];
    if (!rst_n) begin
      m_cyc = 0; m_state = 0; m_ticks = 0; m_moved = 1'b0;
      for (int c = 0; c < 3; c++) begin m_cur[c] = 0; m_tgt[c] = 0; end
    end else begin
      tk = m_tick_now();
      stepnow = (m_state == 2) && tk && (((m_ticks + 1) % FADE_DIV) == 0);
      alldone = 1'b1;
      for (int c = 0; c < 3; c++) begin
        if (m_cur[c] != m_tgt[c]) alldone = 1'b0;
        nc[c] = m_cur[c];
        if (m_state == 1 && tk) nc[c] = m_tgt[c];
        else if (stepnow && m_tgt[c] > m_cur[c]) nc[c] = m_cur[c] + 1;
        else if (stepnow && m_tgt[c] < m_cur[c]) nc[c] = m_cur[c] - 1;
      end
      if (valid) begin
        m_tgt[0] = int'(cr); m_tgt[1] = int'(cg); m_tgt[2] = int'(cb);
        m_state = fade ? 2 : 1;
        m_ticks = 0;
        m_moved = 1'b0;
      end else if (m_state == 1 && tk) begin
        m_state = 0;
      end else if (m_state == 2) begin
        if (alldone && (stepnow || m_moved)) m_state = 0;
        if (stepnow) m_moved = 1'b1;
        if (tk) m_ticks++;
      end
      for (int c = 0; c < 3; c++) m_cur[c] = nc[c];
      m_cyc++;
    end
  end

  // Advance (from a negedge) to the next negedge where o_period_tick is high, bounded.
  task automatic tick_wait(output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < int'(PERIOD) + 8) begin
      if (tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  // Count high slots over one period; call one negedge after a tick, returns on the next tick.
  task automatic measure(output int nr, output int ng, output int nb);
    nr = 0; ng = 0; nb = 0;
    repeat (PERIOD - 1) begin
      @(negedge clk);
      nr += int'(pwm_r);
      ng += int'(pwm_g);
      nb += int'(pwm_b);
    end
  endtask

  // One-cycle colour request, issued from a negedge.
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic f);
    cr = r; cg = g; cb = b; fade = f; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  function automatic logic [7:0] near(input int c);
    int v;
    v = c + int'($urandom_range(0, 6)) - 3;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm_r, pwm_g, pwm_b, busy, tick, ready} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {pwm_r, pwm_g, pwm_b, busy, tick, ready}, 6'b000001);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, tick, ready} !== 3'b001) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", {busy, tick, ready}, 3'b001);
    end
  endtask

  task automatic test_snap_basic();
    bit ok;
    int r, g, b;
    send(8'h80, 8'h00, 8'hFF, 1'b0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL snap_busy_pending got=%b exp=1", busy); end
    tick_wait(ok);
    checks++;
    if (!(ok && m_tick_now())) begin failures++; $display("FAIL snap_tick got=%0d exp=1", ok); end
    @(negedge clk);
    measure(r, g, b);
    checks++;
    if (r !== 128 || g !== 0 || b !== 255) begin
      failures++;
      $display("FAIL snap_duty got=%0d/%0d/%0d exp=128/0/255", r, g, b);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL snap_busy_done got=%b exp=0", busy); end
  endtask

  task automatic test_midperiod();
    bit ok;
    int r, g, b;
    logic [2:0] e;
    tick_wait(ok);
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 128) begin cr = 8'h20; cg = 8'hC0; cb = 8'h10; fade = 1'b0; valid = 1'b1; end
      if (k == 129) valid = 1'b0;
      e = {(k >= 2) && (k - 2 < 128), 1'b0, (k >= 2) && (k - 2 < 255)};
      checks++;
      if ({pwm_r, pwm_g, pwm_b} !== e) begin
        failures++;
        $display("FAIL midperiod_old_duty k=%0d got=%b exp=%b", k, {pwm_r, pwm_g, pwm_b}, e);
      end
    end
    checks++;
    if (tick !== 1'b1) begin failures++; $display("FAIL midperiod_tick got=%b exp=1", tick); end
    @(negedge clk);
    measure(r, g, b);
    checks++;
    if (r !== 32 || g !== 192 || b !== 16) begin
      failures++;
      $display("FAIL midperiod_new_duty got=%0d/%0d/%0d exp=32/192/16", r, g, b);
    end
  endtask

  task automatic test_fade_up();
    bit ok;
    int r, g, b;
    @(negedge clk);
    send(8'h00, 8'h00, 8'h00, 1'b0);
    tick_wait(ok);
    @(negedge clk);
    send(8'h04, 8'h00, 8'h00, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick_wait(ok);
      checks++;
      if (!(ok && m_tick_now())) begin failures++; $display("FAIL fade_up_tick i=%0d got=%0d exp=1", i, ok); end
      if (i < 8) begin
        @(negedge clk);
        measure(r, g, b);
        checks++;
        if (r !== i / 2 || g !== 0 || b !== 0 || r !== m_cur[0]) begin
          failures++;
          $display("FAIL fade_up_duty i=%0d got=%0d/%0d/%0d exp=%0d/0/0", i, r, g, b, i / 2);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL fade_up_busy_hold got=%b exp=1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL fade_up_busy_fall got=%b exp=0", busy); end
    tick_wait(ok);
    @(negedge clk);
    measure(r, g, b);
    checks++;
    if (r !== 4) begin failures++; $display("FAIL fade_up_final got=%0d exp=4", r); end
  endtask

  task automatic test_fade_reverse();
    bit ok;
    int r, g, b;
    tick_wait(ok);
    @(negedge clk);
    send(8'd10, 8'h00, 8'h00, 1'b0);
    tick_wait(ok);
    @(negedge clk);
    send(8'd0, 8'h00, 8'h00, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick_wait(ok);
      @(negedge clk);
      measure(r, g, b);
      checks++;
      if (r !== 10 - i / 2 || r !== m_cur[0]) begin
        failures++;
        $display("FAIL fade_down_duty i=%0d got=%0d exp=%0d", i, r, 10 - i / 2);
      end
    end
    @(negedge clk);
    send(8'd20, 8'h00, 8'h00, 1'b1);
    for (int j = 1; j <= 28; j++) begin
      tick_wait(ok);
      @(negedge clk);
      measure(r, g, b);
      checks++;
      if (r !== 6 + j / 2 || r !== m_cur[0]) begin
        failures++;
        $display("FAIL fade_reverse_duty j=%0d got=%0d exp=%0d", j, r, 6 + j / 2);
      end
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL fade_reverse_busy got=%b exp=0", busy); end
  endtask

  task automatic test_coincident();
    bit ok;
    int r, g, b;
    @(negedge clk);
    send(8'h10, 8'hF0, 8'hF0, 1'b0);
    tick_wait(ok);
    cr = 8'h40; cg = 8'hF0; cb = 8'hF0; fade = 1'b0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    measure(r, g, b);
    checks++;
    if (r !== 16 || g !== 240) begin
      failures++;
      $display("FAIL coincident_first got=%0d/%0d exp=16/240", r, g);
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL coincident_busy got=%b exp=1", busy); end
    @(negedge clk);
    measure(r, g, b);
    checks++;
    if (r !== 64 || busy !== 1'b0) begin
      failures++;
      $display("FAIL coincident_second got=%0d busy=%b exp=64 busy=0", r, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int r, g, b;
    tick_wait(ok);
    @(negedge clk);
    send(8'd200, 8'd100, 8'd50, 1'b1);
    repeat (100) @(negedge clk);
    checks++;
    if ({pwm_g, busy} !== 2'b11) begin
      failures++;
      $display("FAIL reset_mid_before got=%b exp=11", {pwm_g, busy});
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm_r, pwm_g, pwm_b, busy, tick, ready} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_mid_async got=%b exp=%b", {pwm_r, pwm_g, pwm_b, busy, tick, ready}, 6'b000001);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({pwm_r, pwm_g, pwm_b, busy, ready} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_mid_release got=%b exp=%b", {pwm_r, pwm_g, pwm_b, busy, ready}, 5'b00001);
    end
    tick_wait(ok);
    @(negedge clk);
    measure(r, g, b);
    checks++;
    if (r !== 0 || g !== 0 || b !== 0) begin
      failures++;
      $display("FAIL reset_mid_dark got=%0d/%0d/%0d exp=0/0/0", r, g, b);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit f;
    int r, g, b;
    int er, eg, eb;
    logic [7:0] nr, ng, nb;
    for (int it = 0; it < 8; it++) begin
      tick_wait(ok);
      @(negedge clk);
      repeat ($urandom_range(0, 200)) @(negedge clk);
      f = 1'($urandom_range(0, 1));
      if (f) begin
        nr = near(m_cur[0]); ng = near(m_cur[1]); nb = near(m_cur[2]);
      end else begin
        nr = 8'($urandom); ng = 8'($urandom); nb = 8'($urandom);
      end
      send(nr, ng, nb, f);
      for (int p = 0; p < 16 && m_state != 0; p++) begin
        tick_wait(ok);
        checks++;
        if (!(ok && m_tick_now())) begin failures++; $display("FAIL rand_tick it=%0d got=%0d exp=1", it, ok); end
        @(negedge clk);
        er = m_cur[0]; eg = m_cur[1]; eb = m_cur[2];
        measure(r, g, b);
        checks++;
        if (r !== er || g !== eg || b !== eb) begin
          failures++;
          $display("FAIL rand_duty it=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", it, r, g, b, er, eg, eb);
        end
      end
      checks++;
      if (busy !== 1'b0 || m_cur[0] != int'(nr) || m_cur[1] != int'(ng) || m_cur[2] != int'(nb)) begin
        failures++;
        $display("FAIL rand_settle it=%0d busy=%b exp busy=0", it, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_snap_basic();
    test_midperiod();
    test_fade_up();
    test_fade_reverse();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
